// File: rtl/fides192_ctrl.sv
// FIDES-192 authenticated-encryption sequencer: INIT, AD, MSG, FIN and TAG phases with a round-constant LFSR.
// Optional protocol-error detection is enabled by defining FIDES192_CTRL_ERR_EN.
module fides192_ctrl #(
    parameter int unsigned NR_INIT = 16,
    parameter int unsigned NR_FIN  = 16
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] ad_len,
    input  logic [7:0] msg_len,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       round_en,
    output logic       init,
    output logic       getdata,
    output logic       outc,
    output logic       final_o,
    output logic [5:0] rcon,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_AD,
        S_MSG,
        S_FIN,
        S_TAG
    } state_t;

    localparam logic [4:0] INIT_LAST = 5'(NR_INIT - 1);
    localparam logic [4:0] FIN_LAST  = 5'(NR_FIN - 1);

    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_rnd;
    logic [7:0] r_ad_cnt;
    logic [7:0] r_msg_cnt;
    logic [5:0] r_rcon;

    always_comb begin
        w_next    = r_state;
        din_ready = 1'b0;
        round_en  = 1'b0;
        init      = 1'b0;
        getdata   = 1'b0;
        outc      = 1'b0;
        final_o   = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_INIT;
            end
            S_INIT: begin
                round_en = 1'b1;
                init     = (r_rnd == 5'd0);
                // Empty phases are skipped directly so no cycle is spent in them.
                if (r_rnd == INIT_LAST) begin
                    if (r_ad_cnt != 8'd0)       w_next = S_AD;
                    else if (r_msg_cnt != 8'd0) w_next = S_MSG;
                    else                        w_next = S_FIN;
                end
            end
            S_AD: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    round_en = 1'b1;
                    getdata  = 1'b1;
                    if (r_ad_cnt == 8'd1) w_next = (r_msg_cnt != 8'd0) ? S_MSG : S_FIN;
                end
            end
            S_MSG: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    round_en = 1'b1;
                    getdata  = 1'b1;
                    outc     = 1'b1;
                    if (r_msg_cnt == 8'd1) w_next = S_FIN;
                end
            end
            S_FIN: begin
                round_en = 1'b1;
                if (r_rnd == FIN_LAST) w_next = S_TAG;
            end
            S_TAG: begin
                final_o = 1'b1;
                done    = 1'b1;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign busy = (r_state != S_IDLE);
    assign rcon = r_rcon;

    always_ff @(posedge ck) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rnd     <= '0;
            r_ad_cnt  <= '0;
            r_msg_cnt <= '0;
            r_rcon    <= '0;
        end else begin
            r_state <= w_next;

            // Round counter restarts whenever a fixed-length phase is left.
            if ((r_state == S_INIT || r_state == S_FIN) && w_next == r_state)
                r_rnd <= r_rnd + 5'd1;
            else
                r_rnd <= '0;

            if (r_state == S_IDLE && start) begin
                r_ad_cnt  <= ad_len;
                r_msg_cnt <= msg_len;
                r_rcon    <= 6'h01;
            end else begin
                if (round_en) r_rcon <= {r_rcon[4:0], r_rcon[5] ^ r_rcon[4]};
                if (r_state == S_AD && din_valid)  r_ad_cnt  <= r_ad_cnt - 8'd1;
                if (r_state == S_MSG && din_valid) r_msg_cnt <= r_msg_cnt - 8'd1;
            end
        end
    end

`ifdef FIDES192_CTRL_ERR_EN
    logic r_err;

    always_ff @(posedge ck) begin
        if (rst)
            r_err <= 1'b0;
        else if ((start && busy) || (din_valid && !din_ready && r_state != S_IDLE))
            r_err <= 1'b1;
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fides192_ctrl.sv
// Scoreboard bench for fides192_ctrl: driver queues per-round and per-run expectations from a phase-level model,
// a negedge monitor pops and compares them against whatever the DUT presents.
module tb_fides192_ctrl;

    localparam int NR_INIT = 16;
    localparam int NR_FIN  = 16;

    logic       ck = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] ad_len = '0;
    logic [7:0] msg_len = '0;
    logic       din_valid = 1'b0;
    logic       din_ready, round_en, init, getdata, outc, final_o, busy, done, err;
    logic [5:0] rcon;

    fides192_ctrl #(.NR_INIT(NR_INIT), .NR_FIN(NR_FIN)) dut (
        .ck(ck), .rst(rst), .start(start), .ad_len(ad_len), .msg_len(msg_len),
        .din_valid(din_valid), .din_ready(din_ready), .round_en(round_en), .init(init),
        .getdata(getdata), .outc(outc), .final_o(final_o), .rcon(rcon), .busy(busy),
        .done(done), .err(err)
    );

    always #5 ck = ~ck;

    typedef struct { int rc; int flags; } ev_t;
    typedef struct { int acc; int done_at; int rc_fin; } run_t;

    ev_t  rq[$];
    run_t runq[$];
    int   ncyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, ncyc, act, exp);
        end
    endtask

    function automatic int lfsr_step(input int r);
        return ((r << 1) & 63) | (((r >> 5) ^ (r >> 4)) & 1);
    endfunction

    function automatic int outs_packed();
        return {25'd0, round_en, init, getdata, outc, final_o, done, din_ready};
    endfunction

    // Monitor: compares DUT outputs against queued expectations every cycle.
    initial begin
        ev_t  e;
        run_t r;
        int   exp_busy;
        forever begin
            @(negedge ck);
            ncyc++;
            if (!rst) begin
                chk("err", int'(err), exp_err);
                exp_busy = (runq.size() > 0 && ncyc > runq[0].acc) ? 1 : 0;
                chk("busy", int'(busy), exp_busy);
                if (!busy) chk("idle_outputs", outs_packed(), 0);
                if (round_en) begin
                    if (rq.size() == 0) begin
                        chk("unexpected_round_en", 1, 0);
                    end else begin
                        e = rq.pop_front();
                        chk("rcon", int'(rcon), e.rc);
                        chk("init_getdata_outc", int'({init, getdata, outc}), e.flags);
                    end
                end else if (busy && !done && rq.size() > 0) begin
                    chk("rcon_hold", int'(rcon), rq[0].rc);
                end
                if (din_ready && !din_valid) chk("stall_quiet", int'({round_en, getdata, outc}), 0);
                if (done) begin
                    if (runq.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        r = runq.pop_front();
                        chk("done_cycle", ncyc - r.acc, r.done_at - r.acc);
                        chk("tag_outputs", int'({final_o, round_en, busy}), 3'b101);
                        chk("rcon_at_tag", int'(rcon), r.rc_fin);
                        chk("rounds_left", rq.size(), 0);
                        rq.delete();
                    end
                end else if (runq.size() > 0 && ncyc >= runq[0].done_at) begin
                    chk("done_late", 0, 1);
                    void'(runq.pop_front());
                    rq.delete();
                end
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while ((busy || runq.size() > 0) && t < 3000) begin
            @(posedge ck); #1;
            t++;
        end
        if (busy || runq.size() > 0) begin
            chk("idle_timeout", 0, 1);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    endtask

    // Drives one run: st_first stalls before the first data block, up to st_max before the others.
    task automatic run(input int ad, input int msg, input int st_first, input int st_max, input bit extra);
        int   nrounds, lf, stalls[$], total;
        ev_t  e;
        run_t r;
        wait_idle();
        nrounds = NR_INIT + ad + msg + NR_FIN;
        lf = 1;
        for (int k = 0; k < nrounds; k++) begin
            e.rc = lf;
            e.flags = ((k == 0) ? 4 : 0)
                    | ((k >= NR_INIT && k < NR_INIT + ad + msg) ? 2 : 0)
                    | ((k >= NR_INIT + ad && k < NR_INIT + ad + msg) ? 1 : 0);
            rq.push_back(e);
            lf = lfsr_step(lf);
        end
        total = 0;
        for (int b = 0; b < ad + msg; b++) begin
            stalls.push_back((b == 0) ? st_first : $urandom_range(st_max, 0));
            total += stalls[b];
        end
        r.acc = ncyc + 1;
        r.done_at = r.acc + 1 + nrounds + total;
        r.rc_fin = lf;
        runq.push_back(r);
        start = 1'b1;
        ad_len = 8'(ad);
        msg_len = 8'(msg);
        @(posedge ck); #1;
        start = 1'b0;
        ad_len = 8'($urandom);
        msg_len = 8'($urandom);
        repeat (NR_INIT) begin @(posedge ck); #1; end
        for (int b = 0; b < ad + msg; b++) begin
            repeat (stalls[b]) begin din_valid = 1'b0; @(posedge ck); #1; end
            din_valid = 1'b1;
            if (extra && b == ad) start = 1'b1;
            @(posedge ck); #1;
            din_valid = 1'b0;
            if (start) begin
                start = 1'b0;
`ifdef FIDES192_CTRL_ERR_EN
                exp_err = 1;
`endif
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge ck);
        #1;
        @(negedge ck);
        chk("reset_outputs", outs_packed(), 0);
        chk("reset_rcon", int'(rcon), 0);
        chk("reset_busy_err", int'({busy, err}), 0);
        @(posedge ck); #1;
        rst = 1'b0;

        run(0, 0, 0, 0, 1'b0);
        run(2, 3, 0, 0, 1'b0);
        run(1, 1, 4, 0, 1'b0);
        run(3, 2, 1, 2, 1'b1);
        run(0, 4, 2, 1, 1'b0);
        run(5, 0, 0, 3, 1'b0);
        run(255, 255, 0, 0, 1'b0);

        // Reset during FIN round 5, with a competing start while reset is held.
        run(0, 0, 0, 0, 1'b0);
        repeat (4) begin @(posedge ck); #1; end
        rst = 1'b1;
        rq.delete();
        runq.delete();
        exp_err = 0;
        @(posedge ck); #1;
        start = 1'b1;
        ad_len = 8'd5;
        @(negedge ck);
        chk("midrun_reset_outputs", outs_packed(), 0);
        chk("midrun_reset_rcon", int'(rcon), 0);
        chk("midrun_reset_busy_err", int'({busy, err}), 0);
        @(posedge ck); #1;
        rst = 1'b0;
        start = 1'b0;
        @(negedge ck);
        chk("reset_beats_start", int'(busy), 0);
        @(posedge ck); #1;

        run(1, 2, 0, 0, 1'b0);
        for (int i = 0; i < 12; i++)
            run($urandom_range(6, 0), $urandom_range(6, 0), $urandom_range(3, 0),
                $urandom_range(2, 0), 1'($urandom_range(1, 0)));
        wait_idle();
        repeat (2) @(posedge ck);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
